// File: rtl/sram_bist_pkg.sv
// March C- BIST shared types: FSM states, march elements, op kinds
// and the per-element table (ops per address, direction, backgrounds).
package sram_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } elem_e;

  typedef enum logic {
    OP_R,
    OP_W
  } op_e;

  typedef struct packed {
    logic two_ops;
    logic up;
    logic rbg;
    logic wbg;
  } elem_cfg_t;

  localparam elem_e LAST_ELEM = M5;

  // Indexed by elem_e; the two unused codes mirror M5.
  localparam elem_cfg_t ELEM_CFG [8] = '{
    '{1'b0, 1'b1, 1'b0, 1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b0, 1'b0, 1'b1},
    '{1'b1, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0}
  };

  function automatic op_e op_kind(
    input elem_e e,
    input logic  second
  );
    return (second || e == M0) ? OP_W : OP_R;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the march: loads 0 or DEPTH-1 and flags
// the terminal address of the current sweep direction.
module sram_bist_addr_gen
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic              ld_up,
  input  logic              step,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (ld) begin
      addr_d = ld_up ? '0 : TOP;
    end else if (step) begin
      addr_d = up ? addr_q + 1'b1 : addr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign tc   = up ? (addr_q == TOP) : (addr_q == '0);

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// March C- BIST initiator for one SRAM bank: one op per cycle, registered
// compare one cycle after the bank's read data, abort on first mismatch.
module sram_bist_march_ctrl
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] wd,
  output logic              banksel,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] dataout
);

  localparam int DEPTH = 2**ADDR_W;

  state_e            state_q, state_d;
  elem_e             elem_q, elem_d;
  logic              op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              banksel_q, banksel_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  elem_e             cmp_elem_q, cmp_elem_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;

  logic              ag_ld;
  logic              ag_ld_up;
  logic              ag_step;
  logic              ag_up;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_tc;

  logic              issue;
  logic              is_wr;
  logic              last_op;
  logic              mism;

  sram_bist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ag_ld),
    .ld_up (ag_ld_up),
    .step  (ag_step),
    .up    (ag_up),
    .addr  (ag_addr),
    .tc    (ag_tc)
  );

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    issue       = 1'b0;
    ag_ld       = 1'b0;
    ag_ld_up    = 1'b1;
    ag_step     = 1'b0;
    ag_up       = ELEM_CFG[elem_q].up;
    last_op     = !ELEM_CFG[elem_q].two_ops || op_q;
    mism        = cmp_vld_q && (dataout != cmp_exp_q);
    cmp_vld_d   = 1'b0;
    cmp_exp_d   = {DATA_W{ELEM_CFG[elem_q].rbg}};
    cmp_elem_d  = elem_q;
    cmp_addr_d  = ag_addr;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = M0;
          op_d        = 1'b0;
          ag_ld       = 1'b1;
          issue       = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      S_RUN: begin
        cmp_vld_d = read_q;
        if (mism) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
        end else if (!last_op) begin
          op_d  = 1'b1;
          issue = 1'b1;
        end else if (!ag_tc) begin
          op_d    = 1'b0;
          ag_step = 1'b1;
          issue   = 1'b1;
        end else if (elem_q == LAST_ELEM) begin
          // Final read is in flight; its compare lands next cycle.
          state_d = S_DRAIN;
        end else begin
          elem_d   = elem_e'(elem_q + 3'd1);
          op_d     = 1'b0;
          ag_ld    = 1'b1;
          ag_ld_up = ELEM_CFG[elem_d].up;
          issue    = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = !mism;
        if (mism) begin
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    is_wr     = (op_kind(elem_d, op_d) == OP_W);
    banksel_d = issue;
    read_d    = issue && !is_wr;
    write_d   = issue && is_wr;
    wd_d      = (issue && is_wr) ?
                {DATA_W{ELEM_CFG[elem_d].wbg}} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= M0;
      op_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      wd_q        <= '0;
      banksel_q   <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_elem_q  <= M0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      wd_q        <= wd_d;
      banksel_q   <= banksel_d;
      read_q      <= read_d;
      write_q     <= write_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_elem_q  <= cmp_elem_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign ADDRESS   = ag_addr;
  assign wd        = wd_q;
  assign banksel   = banksel_q;
  assign read      = read_q;
  assign write     = write_q;

endmodule

// File: tb/tb_sram_bist_march_ctrl.sv
// Directed bench for sram_bist_march_ctrl on a 16-word behavioral bank
// with selectable stuck-at and coupling faults.
module tb_sram_bist_march_ctrl;

  localparam int AW = 4;
  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] wd;
  logic          banksel;
  logic          read;
  logic          write;
  logic [DW-1:0] dataout;

  logic [DW-1:0] mem [16];
  int            fmode = 0;
  int            checks = 0;
  int            failures = 0;
  int            overlap = 0;
  int            cyc;
  logic [7:0]    e8;

  always #5 clk = ~clk;

  sram_bist_march_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .ADDRESS   (ADDRESS),
    .wd        (wd),
    .banksel   (banksel),
    .read      (read),
    .write     (write),
    .dataout   (dataout)
  );

  function automatic logic [DW-1:0] faulty(
    input logic [AW-1:0] a,
    input logic [DW-1:0] w,
    input int            m
  );
    logic [DW-1:0] r;
    r = w;
    if (m == 1 && a == 4'd3) r[5] = 1'b1;
    if (m == 2 && a == 4'd15) r[39] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (banksel && write) begin
      mem[ADDRESS] <= wd;
      if (fmode == 3 && ADDRESS == 4'd8 && wd == '1) mem[7] <= '1;
    end
    if (banksel && read) dataout <= faulty(ADDRESS, mem[ADDRESS], fmode);
  end

  always @(negedge clk) begin
    if (read && write) overlap <= overlap + 1;
  end

  // {write background, banksel, read, write, address} for op k
  function automatic logic [7:0] exp_op(input int k);
    int e;
    int j;
    int a;
    logic rd;
    logic bg;
    if (k < 16) begin
      a = k; rd = 1'b0; bg = 1'b0;
    end else if (k >= 144) begin
      a = k - 144; rd = 1'b1; bg = 1'b0;
    end else begin
      e  = 1 + (k - 16) / 32;
      j  = (k - 16) % 32;
      a  = (e <= 2) ? j / 2 : 15 - j / 2;
      rd = (j % 2 == 0);
      bg = (e == 1 || e == 3);
    end
    return {bg, 1'b1, rd, !rd, 4'(a)};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, pass, fail_addr, fail_elem,
                    ADDRESS, banksel, read, write}, 64'd0);
    chk("rst_wd", wd, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // clean run, every op cycle checked
    pulse_start();
    for (int k = 0; k < 160; k++) begin
      if (k > 0) @(negedge clk);
      e8 = exp_op(k);
      chk($sformatf("op%0d", k), {banksel, read, write, ADDRESS}, e8[6:0]);
      if (e8[4]) chk($sformatf("wd%0d", k), wd, {DW{e8[7]}});
    end
    @(negedge clk);
    chk("c160", {busy, done, banksel, read, write}, 5'b10000);
    @(negedge clk);
    chk("c161", {busy, done, pass, fail_addr, fail_elem}, {3'b011, 7'd0});

    // stuck-at-1 bit 5 @3: M1 read of addr 3, op 22
    fmode = 1;
    pulse_start();
    wait_done(cyc);
    chk("sa1_cyc", cyc, 24);
    chk("sa1_res", {pass, fail_elem, fail_addr}, {1'b0, 3'd1, 4'd3});
    chk("sa1_ctl", {busy, banksel, read, write}, 4'b0000);

    // stuck-at-0 bit 39 @15: M2 read of addr 15, op 78
    fmode = 2;
    pulse_start();
    chk("restart_clr", {busy, done, pass, fail_addr, fail_elem},
        {3'b100, 7'd0});
    wait_done(cyc);
    chk("sa0_cyc", cyc, 80);
    chk("sa0_res", {pass, fail_elem, fail_addr}, {1'b0, 3'd2, 4'd15});
    chk("sa0_ctl", {busy, banksel, read, write}, 4'b0000);

    // coupling 8->7: M3 read of addr 7, op 96
    fmode = 3;
    pulse_start();
    wait_done(cyc);
    chk("cf_cyc", cyc, 98);
    chk("cf_res", {pass, fail_elem, fail_addr}, {1'b0, 3'd3, 4'd7});

    // async reset at op 50, then clean run
    fmode = 0;
    pulse_start();
    repeat (50) @(negedge clk);
    chk("pre_rst", {busy, banksel}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {busy, done, pass, fail_addr, fail_elem,
                     ADDRESS, banksel, read, write}, 64'd0);
    chk("arst_wd", wd, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_done(cyc);
    chk("post_rst_cyc", cyc, 161);
    chk("post_rst_pass", {pass, fail_addr}, {1'b1, 4'd0});

    // start pulses mid-run ignored, then start held into DONE
    pulse_start();
    for (int c = 1; c <= 161; c++) begin
      @(negedge clk);
      if (c == 9 || c == 99) start = 1'b1;
      if (c == 10 || c == 100) start = 1'b0;
      if (c == 160) begin
        chk("pulse_c160", {busy, done}, 2'b10);
        start = 1'b1;
      end
    end
    chk("pulse_done", {busy, done, pass}, 3'b011);
    @(negedge clk);
    chk("hold_restart", {busy, done, pass, banksel, write, ADDRESS},
        {5'b10011, 4'd0});
    start = 1'b0;
    wait_done(cyc);
    chk("hold_cyc", cyc, 161);
    chk("hold_pass", pass, 1);

    chk("rw_excl", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
